// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell position type, controller states and free-cell search
package ttt_pkg;
  typedef logic [3:0] pos_t;
  localparam pos_t POS_NONE = 4'd0;
  localparam pos_t POS_MIN = 4'd1;
  localparam pos_t POS_MAX = 4'd9;
  typedef enum logic [1:0] {SELECT, ISSUE, SETTLE, DONE} ctrl_state_t;
  function automatic pos_t lowest_free(input logic [8:0] occ);
    lowest_free = POS_NONE;
    for (int i = 8; i >= 0; i--) if (!occ[i]) lowest_free = pos_t'(i + 1);
  endfunction
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and rising-edge detect one raw button
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2, level;
  logic [CW-1:0] cnt;
  // accept a new level only after it differs from the held one for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, level, pulse} <= '0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      pulse <= 1'b0;
      if (s2 == level) cnt <= '0;
      else if (cnt == LAST) begin
        level <= s2;
        cnt <= '0;
        pulse <= s2;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/move_input_controller.sv
// move_input_controller: buttons to legal playX/playO strobes; TURN_TIMEOUT_EN adds a turn auto-confirm timer
module move_input_controller
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int SETTLE_CYCLES = 2
`ifdef TURN_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 500_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_confirm,
  input  logic [8:0] occupied,
  input  logic       game_over,
  output logic       playX,
  output logic       playO,
  output logic [3:0] playerX_position,
  output logic [3:0] playerO_position,
  output logic [3:0] cursor,
  output logic       turn_x
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  ctrl_state_t state, state_d;
  pos_t cursor_d, posx_d, poso_d, sel;
  logic turn_d, go, nxt, prv, cfm, mv_next, mv_prev;
  logic [SW-1:0] scnt, scnt_d;
`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] timer, timer_d;
  pos_t free;
  assign free = lowest_free(occupied);
`endif
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .rst(rst), .btn(btn_next), .pulse(nxt));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (.clk(clk), .rst(rst), .btn(btn_prev), .pulse(prv));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cfm (.clk(clk), .rst(rst), .btn(btn_confirm), .pulse(cfm));
  assign mv_next = nxt & ~prv;
  assign mv_prev = prv & ~nxt;
  assign playX = state == ISSUE && turn_x;
  assign playO = state == ISSUE && !turn_x;
  // next-state, cursor movement and move capture
  always_comb begin
    state_d = state;
    cursor_d = cursor;
    turn_d = turn_x;
    posx_d = playerX_position;
    poso_d = playerO_position;
    scnt_d = '0;
    go = 1'b0;
    sel = cursor;
`ifdef TURN_TIMEOUT_EN
    timer_d = '0;
`endif
    case (state)
      SELECT: begin
`ifdef TURN_TIMEOUT_EN
        timer_d = timer == T_MAX ? timer : timer + 1'b1;
`endif
        if (game_over) state_d = DONE;
        else if (cfm) go = !occupied[cursor - 4'd1];
`ifdef TURN_TIMEOUT_EN
        else if (timer == T_MAX) begin
          go = free != POS_NONE;
          sel = free;
          cursor_d = go ? free : cursor;
        end
`endif
        else if (mv_next || mv_prev) begin
          cursor_d = mv_next ? (cursor == POS_MAX ? POS_MIN : cursor + 4'd1)
                             : (cursor == POS_MIN ? POS_MAX : cursor - 4'd1);
`ifdef TURN_TIMEOUT_EN
          timer_d = '0;
`endif
        end
        if (go) begin
          state_d = ISSUE;
          posx_d = turn_x ? sel : playerX_position;
          poso_d = turn_x ? playerO_position : sel;
        end
      end
      ISSUE: state_d = SETTLE;
      SETTLE: begin
        if (scnt == S_LAST) begin
          turn_d = ~turn_x;
          state_d = game_over ? DONE : SELECT;
        end else scnt_d = scnt + 1'b1;
      end
      default: state_d = DONE;
    endcase
  end
  // controller state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SELECT;
      cursor <= POS_MIN;
      turn_x <= 1'b1;
      playerX_position <= POS_NONE;
      playerO_position <= POS_NONE;
      scnt <= '0;
`ifdef TURN_TIMEOUT_EN
      timer <= '0;
`endif
    end else begin
      state <= state_d;
      cursor <= cursor_d;
      turn_x <= turn_d;
      playerX_position <= posx_d;
      playerO_position <= poso_d;
      scnt <= scnt_d;
`ifdef TURN_TIMEOUT_EN
      timer <= timer_d;
`endif
    end
  end
endmodule

// File: tb/tb_move_input_controller.sv
// tb_move_input_controller: directed vector table plus hand sequences for move_input_controller
module tb_move_input_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic btn_next = 1'b0, btn_prev = 1'b0, btn_confirm = 1'b0, game_over = 1'b0;
  logic [8:0] occupied = '0;
  logic playX, playO, turn_x;
  logic [3:0] playerX_position, playerO_position, cursor;
  int total = 0, bad = 0, nx = 0, no = 0, both = 0;
  typedef struct {
    logic n, p, c;
    logic [8:0] occ;
    int cur, turn, px, po, sx, so;
  } vec_t;
  vec_t v[20];
  move_input_controller #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES(2)
`ifdef TURN_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev), .btn_confirm(btn_confirm),
    .occupied(occupied), .game_over(game_over), .playX(playX), .playO(playO),
    .playerX_position(playerX_position), .playerO_position(playerO_position),
    .cursor(cursor), .turn_x(turn_x)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    nx += int'(playX);
    no += int'(playO);
    if (playX && playO) both++;
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic act(input logic n, input logic p, input logic c);
    btn_next = n;
    btn_prev = p;
    btn_confirm = c;
    repeat (10) @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_confirm = 1'b0;
    repeat (14) @(negedge clk);
  endtask
  initial begin
    int bx, bo, k;
    v[0]  = '{1, 0, 0, 9'b000000000, 2, 1, 0, 0, 0, 0};
    v[1]  = '{1, 0, 0, 9'b000000000, 3, 1, 0, 0, 0, 0};
    v[2]  = '{1, 0, 0, 9'b000000000, 4, 1, 0, 0, 0, 0};
    v[3]  = '{0, 1, 0, 9'b000000000, 3, 1, 0, 0, 0, 0};
    v[4]  = '{0, 1, 0, 9'b000000000, 2, 1, 0, 0, 0, 0};
    v[5]  = '{0, 1, 0, 9'b000000000, 1, 1, 0, 0, 0, 0};
    v[6]  = '{0, 1, 0, 9'b000000000, 9, 1, 0, 0, 0, 0};
    v[7]  = '{1, 0, 0, 9'b000000000, 1, 1, 0, 0, 0, 0};
    v[8]  = '{1, 1, 0, 9'b000000000, 1, 1, 0, 0, 0, 0};
    v[9]  = '{1, 0, 0, 9'b000000000, 2, 1, 0, 0, 0, 0};
    v[10] = '{1, 0, 0, 9'b000000000, 3, 1, 0, 0, 0, 0};
    v[11] = '{1, 0, 0, 9'b000000000, 4, 1, 0, 0, 0, 0};
    v[12] = '{1, 0, 0, 9'b000000000, 5, 1, 0, 0, 0, 0};
    v[13] = '{0, 0, 1, 9'b000000000, 5, 0, 5, 0, 1, 0};
    v[14] = '{0, 0, 1, 9'b000010000, 5, 0, 5, 0, 0, 0};
    v[15] = '{1, 0, 0, 9'b000010000, 6, 0, 5, 0, 0, 0};
    v[16] = '{0, 0, 1, 9'b000010000, 6, 1, 5, 6, 0, 1};
    v[17] = '{1, 0, 1, 9'b000110000, 6, 1, 5, 6, 0, 0};
    v[18] = '{1, 0, 0, 9'b000110000, 7, 1, 5, 6, 0, 0};
    v[19] = '{1, 0, 1, 9'b000110000, 7, 0, 7, 6, 1, 0};
    repeat (3) @(negedge clk);
    chk("reset cursor", int'(cursor), 1);
    chk("reset turn_x", int'(turn_x), 1);
    chk("reset posX", int'(playerX_position), 0);
    chk("reset posO", int'(playerO_position), 0);
    chk("reset strobes", int'(playX) + int'(playO), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      occupied = v[i].occ;
      bx = nx;
      bo = no;
      act(v[i].n, v[i].p, v[i].c);
      chk($sformatf("v%0d cursor", i), int'(cursor), v[i].cur);
      chk($sformatf("v%0d turn_x", i), int'(turn_x), v[i].turn);
      chk($sformatf("v%0d posX", i), int'(playerX_position), v[i].px);
      chk($sformatf("v%0d posO", i), int'(playerO_position), v[i].po);
      chk($sformatf("v%0d playX cycles", i), nx - bx, v[i].sx);
      chk($sformatf("v%0d playO cycles", i), no - bo, v[i].so);
    end
    for (int j = 0; j < 10; j++) begin
      btn_next = (j % 2 == 0);
      repeat (2) @(negedge clk);
    end
    act(1, 0, 0);
    chk("bounce cursor", int'(cursor), 8);
    occupied = 9'b001110000;
    btn_confirm = 1'b1;
    k = 0;
    while (!playO && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("settle strobe seen", int'(playO), 1);
    chk("settle playX low", int'(playX), 0);
    chk("settle turn at strobe", int'(turn_x), 0);
    chk("settle posO", int'(playerO_position), 8);
    @(negedge clk);
    chk("settle strobe width", int'(playO), 0);
    game_over = 1'b1;
    @(negedge clk);
    chk("settle turn held", int'(turn_x), 0);
    @(negedge clk);
    chk("settle turn toggled", int'(turn_x), 1);
    btn_confirm = 1'b0;
    repeat (10) @(negedge clk);
    bx = nx;
    bo = no;
    act(1, 0, 1);
    act(0, 1, 0);
    chk("done cursor", int'(cursor), 8);
    chk("done strobes", (nx - bx) + (no - bo), 0);
    chk("done posO", int'(playerO_position), 8);
    rst = 1'b1;
    @(negedge clk);
    chk("rst cursor", int'(cursor), 1);
    chk("rst turn_x", int'(turn_x), 1);
    chk("rst posX", int'(playerX_position), 0);
    chk("rst posO", int'(playerO_position), 0);
    game_over = 1'b0;
    occupied = '0;
    @(negedge clk);
    chk("rst strobes", int'(playX) + int'(playO), 0);
    rst = 1'b0;
    @(negedge clk);
`ifdef TURN_TIMEOUT_EN
    occupied = 9'b000000011;
    bx = nx;
    repeat (60) @(negedge clk);
    chk("timeout cursor", int'(cursor), 3);
    chk("timeout posX", int'(playerX_position), 3);
    chk("timeout playX cycles", nx - bx, 1);
`else
    act(1, 0, 0);
    chk("after rst next", int'(cursor), 2);
`endif
    chk("exclusive strobes", both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
